// File: rtl/ec_reg_bank_if.sv
// Control/debug bus of the register bank: operation strobe,
// operand and read address in, read data and status out.
interface ec_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             we;
    logic [2:0]       op;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] dout;
    logic             flag_z;
    logic             flag_c;
    logic             locked;
    logic             err;

    modport master (
        output we, op, addr, din, rd_addr,
        input  dout, flag_z, flag_c, locked, err
    );

    modport slave (
        input  we, op, addr, din, rd_addr,
        output dout, flag_z, flag_c, locked, err
    );
endinterface

// File: rtl/ec_reg_bank.sv
// Key-guarded bank of externally controlled registers with
// per-write ALU ops, status flags and a registered read port.
module ec_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter int               NREGS     = 4,
    parameter int               AW        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(8'h55),
    parameter int               LOCK_EN   = 1,
    parameter logic [WIDTH-1:0] KEY1      = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0] KEY2      = WIDTH'(8'h5A)
) (
    input logic        clk,
    input logic        reset,
    ec_reg_bank_if.slave bus
);
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_KEY  = 3'd7;

    localparam logic [1:0] ST_LOCKED = 2'd0;
    localparam logic [1:0] ST_KEY1   = 2'd1;
    localparam logic [1:0] ST_UNLK   = 2'd2;
    localparam logic [1:0] ST_RST    = (LOCK_EN != 0) ? ST_LOCKED : ST_UNLK;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             err_q, err_d;

    logic             is_key, is_data, in_range, rd_ok, exec;
    logic [IW-1:0]    widx, ridx;
    logic [WIDTH-1:0] cur, res;
    logic [WIDTH:0]   sum, diff;
    logic             cout;

    assign is_key   = (bus.op == OP_KEY);
    assign is_data  = (bus.op != OP_NOP) && !is_key;
    assign in_range = int'(bus.addr) < NREGS;
    assign rd_ok    = int'(bus.rd_addr) < NREGS;
    assign widx     = bus.addr[IW-1:0];
    assign ridx     = bus.rd_addr[IW-1:0];

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        exec    = 1'b0;
        if (bus.we) begin
            case (state_q)
                ST_LOCKED: begin
                    if (is_key && bus.din == KEY1) state_d = ST_KEY1;
                    else if (is_data)              err_d   = 1'b1;
                end
                ST_KEY1: begin
                    // Anything but the second key aborts the sequence.
                    if (is_key && bus.din == KEY2) begin
                        state_d = ST_UNLK;
                    end else begin
                        state_d = ST_LOCKED;
                        err_d   = 1'b1;
                    end
                end
                ST_UNLK: begin
                    if (is_key) begin
                        state_d = ST_RST;
                    end else if (is_data) begin
                        if (in_range) exec  = 1'b1;
                        else          err_d = 1'b1;
                    end
                end
                default: state_d = ST_RST;
            endcase
        end
    end

    always_comb begin
        cur  = in_range ? regs_q[widx] : '0;
        sum  = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
        diff = {1'b0, cur} - {{WIDTH{1'b0}}, 1'b1};
        res  = cur;
        cout = 1'b0;
        case (bus.op)
            OP_LOAD: res = bus.din;
            OP_INC:  {cout, res} = sum;
            OP_DEC:  {cout, res} = diff;
            OP_SHL:  {cout, res} = {cur, 1'b0};
            OP_SHR:  {res, cout} = {1'b0, cur};
            OP_CLR:  res = '0;
            default: res = cur;
        endcase
        z_d = exec ? (res == '0) : z_q;
        c_d = exec ? cout : c_q;
    end

    // Read samples pre-write contents, giving read-before-write.
    assign dout_d = rd_ok ? regs_q[ridx] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
            state_q <= ST_RST;
            dout_q  <= RESET_VAL;
            z_q     <= (RESET_VAL == '0);
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (exec && int'(widx) == i) regs_q[i] <= res;
            end
            state_q <= state_d;
            dout_q  <= dout_d;
            z_q     <= z_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.flag_z = z_q;
    assign bus.flag_c = c_q;
    assign bus.locked = (state_q != ST_UNLK);
    assign bus.err    = err_q;
endmodule

// File: tb/tb_ec_reg_bank.sv
// Directed plus random checks of ec_reg_bank against a
// behavioural model of the bank, lock sequence and flags.
module tb_ec_reg_bank;
    localparam int NR = 4;
    localparam int AWT = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    int m [NR];
    int st;
    int fz, fc;
    int e_dout, e_err;

    always #5 clk = ~clk;

    ec_reg_bank_if #(.WIDTH(8), .AW(AWT)) bus ();

    ec_reg_bank #(
        .WIDTH(8), .NREGS(NR), .AW(AWT), .RESET_VAL(8'h55),
        .LOCK_EN(1), .KEY1(8'hA5), .KEY2(8'h5A)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m[i] = 'h55;
        st = 0;
        fz = 0;
        fc = 0;
        e_dout = 'h55;
        e_err = 0;
    endtask

    // st: 0 locked, 1 first key seen, 2 unlocked
    task automatic model_edge(input int w, input int o, input int a,
                              input int d, input int rd);
        int v, nv, c;
        e_dout = (rd < NR) ? m[rd] : 0;
        e_err = 0;
        if (w != 0) begin
            if (st == 0) begin
                if (o == 7 && d == 'hA5) st = 1;
                else if (o >= 1 && o <= 6) e_err = 1;
            end else if (st == 1) begin
                if (o == 7 && d == 'h5A) st = 2;
                else begin st = 0; e_err = 1; end
            end else if (o == 7) begin
                st = 0;
            end else if (o >= 1 && o <= 6) begin
                if (a >= NR) e_err = 1;
                else begin
                    v = m[a];
                    nv = v; c = 0;
                    case (o)
                        1: nv = d;
                        2: begin nv = (v + 1) % 256; c = (v == 255); end
                        3: begin nv = (v + 255) % 256; c = (v == 0); end
                        4: begin nv = (v * 2) % 256; c = (v >= 128); end
                        5: begin nv = v / 2; c = v % 2; end
                        default: nv = 0;
                    endcase
                    m[a] = nv;
                    fz = (nv == 0);
                    fc = c;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"}, int'(bus.dout), e_dout);
        chk({tag, ".err"}, int'(bus.err), e_err);
        chk({tag, ".locked"}, int'(bus.locked), (st != 2) ? 1 : 0);
        chk({tag, ".z"}, int'(bus.flag_z), fz);
        chk({tag, ".c"}, int'(bus.flag_c), fc);
    endtask

    task automatic step(input string tag, input int w, input int o,
                        input int a, input int d, input int rd);
        @(negedge clk);
        bus.we = w[0];
        bus.op = o[2:0];
        bus.addr = a[AWT-1:0];
        bus.din = d[7:0];
        bus.rd_addr = rd[AWT-1:0];
        model_edge(w, o, a, d, rd);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int o, a, d, rd, w;
        reset = 1'b1;
        bus.we = 1'b0;
        bus.op = 3'd0;
        bus.addr = '0;
        bus.din = '0;
        bus.rd_addr = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NR; i++) begin
            step("read_rst", 0, 0, 0, 0, i);
            chk("read_rst_const", int'(bus.dout), 'h55);
        end

        step("locked_load", 1, 1, 1, 'h12, 1);
        chk("locked_load_err", int'(bus.err), 1);
        step("key1", 1, 7, 0, 'hA5, 1);
        step("key2", 1, 7, 0, 'h5A, 1);
        chk("unlocked", int'(bus.locked), 0);
        chk("reg1_kept", int'(bus.dout), 'h55);

        step("load2", 1, 1, 2, 'hFF, 2);
        step("inc2", 1, 2, 2, 0, 2);
        chk("inc2_c", int'(bus.flag_c), 1);
        chk("inc2_z", int'(bus.flag_z), 1);
        step("dec2", 1, 3, 2, 0, 2);
        step("rd2", 0, 0, 0, 0, 2);
        chk("dec2_val", int'(bus.dout), 'hFF);

        step("load3", 1, 1, 3, 'h81, 3);
        step("shl3", 1, 4, 3, 0, 3);
        step("shr3", 1, 5, 3, 0, 3);
        step("clr3", 1, 6, 3, 0, 3);
        chk("clr3_z", int'(bus.flag_z), 1);
        step("rd3", 0, 0, 0, 0, 3);

        step("rbw_load", 1, 1, 1, 'h77, 1);
        chk("rbw_old", int'(bus.dout), 'h55);
        step("rbw_new", 0, 0, 0, 0, 1);
        chk("rbw_new_val", int'(bus.dout), 'h77);
        step("oor_load", 1, 1, 4, 'h99, 4);
        chk("oor_err", int'(bus.err), 1);
        step("oor_rd", 0, 0, 0, 0, 5);
        chk("oor_rd_zero", int'(bus.dout), 0);

        step("relock", 1, 7, 0, 'h00, 0);
        step("abort_key1", 1, 7, 0, 'hA5, 0);
        step("abort_load", 1, 1, 0, 'h33, 0);
        step("abort_rd0", 0, 0, 0, 0, 0);

        step("rst_key1", 1, 7, 0, 'hA5, 0);
        bus.we = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_locked", int'(bus.locked), 1);
        chk("async_dout", int'(bus.dout), 'h55);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) step("read_rst2", 0, 0, 0, 0, i);

        for (int n = 0; n < 400; n++) begin
            w = ($urandom_range(0, 4) != 0) ? 1 : 0;
            o = $urandom_range(0, 7);
            a = $urandom_range(0, 4);
            rd = $urandom_range(0, 5);
            d = $urandom_range(0, 255);
            if (o == 7) begin
                case ($urandom_range(0, 3))
                    0: d = 'hA5;
                    1: d = 'h5A;
                    2: d = (st == 1) ? 'h5A : 'hA5;
                    default: ;
                endcase
            end
            if (st == 0 && $urandom_range(0, 2) == 0) begin
                w = 1; o = 7; d = 'hA5;
            end else if (st == 1 && $urandom_range(0, 3) != 0) begin
                w = 1; o = 7; d = 'h5A;
            end
            step("rand", w, o, a, d, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
